instr_sequencer: RTL and testbench

- Fetch/issue controller in front of the processor control unit.
- Reads 9-bit instruction words from a synchronous program ROM at a program counter and drives each word on the processor DIN/IR path.
- Holds run high until the control unit signals done, then advances the PC.
- Provides halt detection, single-step, abort and a done-timeout watchdog, so the processor executes programs without manual run/DIN stimulus.

---
 rtl/instr_sequencer.sv | 138 +++++++++++++
 tb/tb_instr_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: reads 9-bit instruction words from a synchronous ROM
// and presents them one at a time to the processor control unit.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]      HALT_OP   = 3'b111;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [TO_W-1:0]   wdog, wdog_nx;
  logic [8:0]        din_nx;
  logic              run_nx, rd_nx, busy_nx, halted_nx, fault_nx;

  assign mem_addr = pc;
  assign pc_out   = pc;

  always_comb begin
    // NOTE: every target gets a default first, so no path through the block
    // leaves one unassigned and no latch is inferred.
    state_nx  = state;
    pc_nx     = pc;
    wdog_nx   = wdog;
    din_nx    = proc_din;
    run_nx    = proc_run;
    halted_nx = halted;
    fault_nx  = fault;

    if (abort && state != S_IDLE) begin
      state_nx  = S_IDLE;
      run_nx    = 1'b0;
      halted_nx = 1'b0;
      fault_nx  = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) state_nx = S_FETCH;
        end
        S_FETCH: begin
          state_nx = S_LATCH;
        end
        S_LATCH: begin
          // Halt words stop here; proc_din keeps the last real instruction.
          if (mem_rdata[8:6] == HALT_OP) begin
            state_nx  = S_HALTED;
            halted_nx = 1'b1;
          end else begin
            din_nx   = mem_rdata;
            run_nx   = 1'b1;
            wdog_nx  = '0;
            state_nx = S_EXEC;
          end
        end
        S_EXEC: begin
          wdog_nx = wdog + 1'b1;
          if (proc_done) begin
            run_nx   = 1'b0;
            pc_nx    = pc + 1'b1;
            state_nx = step_mode ? S_IDLE : S_FETCH;
          end else if (wdog == WDOG_LAST) begin
            run_nx   = 1'b0;
            fault_nx = 1'b1;
            state_nx = S_FAULT;
          end
        end
        S_HALTED, S_FAULT: begin
          if (start) begin
            halted_nx = 1'b0;
            fault_nx  = 1'b0;
            pc_nx     = '0;
            state_nx  = S_FETCH;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end

    // Strobes are registered from the next state so they line up with it.
    rd_nx   = (state_nx == S_FETCH);
    busy_nx = (state_nx == S_FETCH) || (state_nx == S_LATCH) || (state_nx == S_EXEC);
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      wdog     <= '0;
      proc_din <= '0;
      proc_run <= 1'b0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      wdog     <= wdog_nx;
      proc_din <= din_nx;
      proc_run <= run_nx;
      mem_rd   <= rd_nx;
      busy     <= busy_nx;
      halted   <= halted_nx;
      fault    <= fault_nx;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: ROM and processor models, directed
// scenarios plus randomized programs checked against an arithmetic trace model.
module tb_instr_sequencer;

  localparam int AW      = 5;
  localparam int TIMEOUT = 15;

  logic          clock = 1'b0;
  logic          reset, start, step_mode, abort;
  logic [AW-1:0] mem_addr, pc_out;
  logic          mem_rd;
  logic [8:0]    mem_rdata = '0;
  logic [8:0]    proc_din;
  logic          proc_run, proc_done, busy, halted, fault;

  // Second instance with a 2-bit PC for the wrap-around scenario
  logic       s_start;
  logic [1:0] s_mem_addr, s_pc_out;
  logic       s_mem_rd;
  logic [8:0] s_mem_rdata = '0;
  logic [8:0] s_proc_din;
  logic       s_proc_run, s_proc_done, s_busy, s_halted, s_fault;

  logic [8:0] rom [32];
  int         dur [32];      // run cycles until done; 0 = never done
  logic [8:0] s_rom [4];
  int         run_cnt, s_run_cnt;
  logic       done_force;

  int checks = 0;
  int errors = 0;

  logic [8:0] run_din [$];
  int         run_pc [$];
  int         run_len [$];
  int         run_gap [$];
  int         din_changed;

  always #5 clock = ~clock;

  instr_sequencer #(.ADDR_W(AW), .TIMEOUT(TIMEOUT), .TO_W(4)) u_dut (
    .clock(clock), .reset(reset), .start(start), .step_mode(step_mode), .abort(abort),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .proc_din(proc_din), .proc_run(proc_run), .proc_done(proc_done),
    .pc_out(pc_out), .busy(busy), .halted(halted), .fault(fault)
  );

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(TIMEOUT), .TO_W(4)) u_small (
    .clock(clock), .reset(reset), .start(s_start), .step_mode(step_mode), .abort(abort),
    .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_rdata(s_mem_rdata),
    .proc_din(s_proc_din), .proc_run(s_proc_run), .proc_done(s_proc_done),
    .pc_out(s_pc_out), .busy(s_busy), .halted(s_halted), .fault(s_fault)
  );

  // Synchronous ROMs
  always @(posedge clock) if (mem_rd) mem_rdata <= rom[mem_addr];
  always @(posedge clock) if (s_mem_rd) s_mem_rdata <= s_rom[s_mem_addr];

  // Processor models: done is combinational on the final run cycle
  always @(posedge clock or posedge reset)
    if (reset) run_cnt <= 0; else run_cnt <= proc_run ? run_cnt + 1 : 0;
  always @(posedge clock or posedge reset)
    if (reset) s_run_cnt <= 0; else s_run_cnt <= s_proc_run ? s_run_cnt + 1 : 0;

  assign proc_done   = done_force ||
                       (proc_run && dur[pc_out] != 0 && run_cnt + 1 == dur[pc_out]);
  assign s_proc_done = s_proc_run && s_run_cnt == 1;

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    done_force = 1'b0; s_start = 1'b0;
    for (int i = 0; i < 32; i++) begin rom[i] = '0; dur[i] = 0; end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Follows one run from a start sampled on the next edge until halted or budget.
  task automatic trace(input int budget, output int halt_cyc);
    int         cyc, len, low;
    logic       prev;
    logic [8:0] din0;
    cyc = 0; len = 0; low = 0; prev = 1'b0; din0 = '0; halt_cyc = -1;
    run_din.delete(); run_pc.delete(); run_len.delete(); run_gap.delete();
    din_changed = 0;
    while (cyc < budget && halt_cyc < 0) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (proc_run) begin
        if (!prev) begin
          run_din.push_back(proc_din); run_pc.push_back(int'(pc_out));
          run_gap.push_back(low); low = 0; len = 0; din0 = proc_din;
        end else if (proc_din !== din0) din_changed++;
        len++;
      end else begin
        if (prev) run_len.push_back(len);
        low++;
      end
      if (halted) halt_cyc = cyc;
      prev = proc_run;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    done_force = 1'b0; s_start = 1'b0;
    #1;
    checks++;
    if ({pc_out, proc_din, mem_rd, proc_run, busy, halted, fault} !== '0) begin
      errors++;
      $display("FAIL reset_state got pc=%0d din=%o rd=%b run=%b busy=%b halted=%b fault=%b exp all 0",
               pc_out, proc_din, mem_rd, proc_run, busy, halted, fault);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, mem_rd, proc_run} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got busy/rd/run=%b exp 000", {busy, mem_rd, proc_run});
    end
  endtask

  task automatic test_program();
    int hc;
    do_reset();
    rom[0] = 9'o101; rom[1] = 9'o210; rom[2] = 9'o777; dur[0] = 2; dur[1] = 4;
    @(negedge clock); start = 1'b1;
    trace(40, hc);
    checks++; if (hc != 13) begin errors++; $display("FAIL prog_halt_cycle got %0d exp 13", hc); end
    checks++; if (run_din.size() != 2) begin errors++; $display("FAIL prog_runs got %0d exp 2", run_din.size()); end
    checks++; if (run_din[0] !== 9'o101 || run_len[0] != 2) begin
      errors++; $display("FAIL prog_run0 got din=%o len=%0d exp din=101 len=2", run_din[0], run_len[0]); end
    checks++; if (run_din[1] !== 9'o210 || run_len[1] != 4) begin
      errors++; $display("FAIL prog_run1 got din=%o len=%0d exp din=210 len=4", run_din[1], run_len[1]); end
    for (int i = 0; i < run_gap.size(); i++) begin
      checks++; if (run_gap[i] != 2) begin errors++; $display("FAIL prog_gap%0d got %0d exp 2", i, run_gap[i]); end
    end
    checks++; if (din_changed != 0) begin errors++; $display("FAIL prog_din_stable got %0d changes exp 0", din_changed); end
    checks++; if ({halted, proc_run, busy} !== 3'b100 || pc_out !== 5'd2) begin
      errors++; $display("FAIL prog_halted got halted/run/busy=%b pc=%0d exp 100 pc=2", {halted, proc_run, busy}, pc_out); end
  endtask

  task automatic test_step_mode();
    do_reset();
    rom[0] = 9'o101; rom[1] = 9'o210; rom[2] = 9'o777; dur[0] = 2; dur[1] = 4;
    step_mode = 1'b1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (pc_out !== 5'd1 || proc_run !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL step_idle got pc=%0d run=%b busy=%b exp pc=1 run=0 busy=0", pc_out, proc_run, busy); end
    repeat (3) @(negedge clock);
    checks++; if (pc_out !== 5'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL step_hold got pc=%0d busy=%b exp pc=1 busy=0", pc_out, busy); end
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (proc_run !== 1'b1 || proc_din !== 9'o210) begin
      errors++; $display("FAIL step_second got run=%b din=%o exp run=1 din=210", proc_run, proc_din); end
    repeat (4) @(negedge clock);
    checks++; if (pc_out !== 5'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL step_second_done got pc=%0d busy=%b exp pc=2 busy=0", pc_out, busy); end
    step_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt, cyc;
    do_reset();
    rom[0] = 9'o101; dur[0] = 1; rom[1] = 9'o123; dur[1] = 0;
    @(negedge clock); start = 1'b1;
    cnt = 0; cyc = 0;
    while (cyc < 60 && fault !== 1'b1) begin
      @(negedge clock); start = 1'b0; cyc++;
      if (proc_run && pc_out == 5'd1) cnt++;
    end
    checks++; if (cnt != TIMEOUT) begin errors++; $display("FAIL timeout_exec_cycles got %0d exp %0d", cnt, TIMEOUT); end
    checks++; if ({fault, proc_run, busy, halted} !== 4'b1000 || pc_out !== 5'd1) begin
      errors++; $display("FAIL timeout_fault got fault/run/busy/halted=%b pc=%0d exp 1000 pc=1",
                         {fault, proc_run, busy, halted}, pc_out); end
    @(negedge clock);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_hold got fault=%b exp 1", fault); end
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++; if ({fault, busy, mem_rd} !== 3'b011 || pc_out !== 5'd0) begin
      errors++; $display("FAIL timeout_restart got fault/busy/rd=%b pc=%0d exp 011 pc=0", {fault, busy, mem_rd}, pc_out); end
  endtask

  task automatic test_abort();
    do_reset();
    rom[0] = 9'o101; dur[0] = 1; rom[1] = 9'o210; dur[1] = 5;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (proc_run !== 1'b1 || pc_out !== 5'd1) begin
      errors++; $display("FAIL abort_pre got run=%b pc=%0d exp run=1 pc=1", proc_run, pc_out); end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    checks++; if ({proc_run, busy, mem_rd} !== 3'b000 || pc_out !== 5'd1) begin
      errors++; $display("FAIL abort_idle got run/busy/rd=%b pc=%0d exp 000 pc=1", {proc_run, busy, mem_rd}, pc_out); end
    done_force = 1'b1;
    @(negedge clock); done_force = 1'b0;
    @(negedge clock);
    checks++; if (pc_out !== 5'd1 || proc_run !== 1'b0) begin
      errors++; $display("FAIL abort_stray_done got pc=%0d run=%b exp pc=1 run=0", pc_out, proc_run); end
    start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_blocks_start got busy=%b exp 0", busy); end
  endtask

  task automatic test_wrap();
    logic [8:0] seen_din [$];
    int         seen_pc [$];
    logic       prev;
    int         cyc;
    do_reset();
    s_rom[0] = 9'o011; s_rom[1] = 9'o022; s_rom[2] = 9'o033; s_rom[3] = 9'o044;
    @(negedge clock); s_start = 1'b1;
    prev = 1'b0; cyc = 0;
    while (cyc < 80 && seen_din.size() < 6) begin
      @(negedge clock); s_start = 1'b0; cyc++;
      if (s_proc_run && !prev) begin seen_din.push_back(s_proc_din); seen_pc.push_back(int'(s_pc_out)); end
      prev = s_proc_run;
    end
    checks++; if (seen_din.size() != 6) begin errors++; $display("FAIL wrap_runs got %0d exp 6", seen_din.size()); end
    for (int i = 0; i < seen_din.size(); i++) begin
      checks++;
      if (seen_din[i] !== s_rom[i % 4] || seen_pc[i] != i % 4) begin
        errors++; $display("FAIL wrap_run%0d got din=%o pc=%0d exp din=%o pc=%0d",
                           i, seen_din[i], seen_pc[i], s_rom[i % 4], i % 4);
      end
    end
    abort = 1'b1;
    @(negedge clock); abort = 1'b0;
    checks++; if (s_busy !== 1'b0 || s_proc_run !== 1'b0) begin
      errors++; $display("FAIL wrap_abort got busy=%b run=%b exp 0 0", s_busy, s_proc_run); end
  endtask

  task automatic test_random();
    int         len, hc, exp_hc;
    int         d [6];
    logic [8:0] w [6];
    for (int it = 0; it < 8; it++) begin
      do_reset();
      len = int'($urandom_range(1, 6));
      exp_hc = 3;
      for (int i = 0; i < len; i++) begin
        w[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
        d[i] = int'($urandom_range(1, TIMEOUT));
        rom[i] = w[i]; dur[i] = d[i];
        exp_hc += 2 + d[i];
      end
      rom[len] = {3'b111, 6'($urandom)};
      for (int pass = 0; pass < 2; pass++) begin
        @(negedge clock); start = 1'b1;
        trace(300, hc);
        checks++; if (hc != exp_hc) begin
          errors++; $display("FAIL rand%0d.%0d_halt_cycle got %0d exp %0d", it, pass, hc, exp_hc); end
        checks++; if (run_din.size() != len || din_changed != 0) begin
          errors++; $display("FAIL rand%0d.%0d_runs got %0d (din changes %0d) exp %0d", it, pass, run_din.size(), din_changed, len); end
        for (int i = 0; i < run_din.size() && i < len; i++) begin
          checks++;
          if (run_din[i] !== w[i] || run_pc[i] != i || run_len[i] != d[i] || run_gap[i] != 2) begin
            errors++; $display("FAIL rand%0d.%0d_run%0d got din=%o pc=%0d len=%0d gap=%0d exp din=%o pc=%0d len=%0d gap=2",
                               it, pass, i, run_din[i], run_pc[i], run_len[i], run_gap[i], w[i], i, d[i]);
          end
        end
        checks++; if (halted !== 1'b1 || pc_out !== AW'(len)) begin
          errors++; $display("FAIL rand%0d.%0d_halted got halted=%b pc=%0d exp 1 pc=%0d", it, pass, halted, pc_out, len); end
      end
      abort = 1'b1;
      @(negedge clock); abort = 1'b0;
      checks++; if (halted !== 1'b0 || pc_out !== AW'(len)) begin
        errors++; $display("FAIL rand%0d_abort_halted got halted=%b pc=%0d exp 0 pc=%0d", it, halted, pc_out, len); end
    end
  endtask

  task automatic test_reset_mid_exec();
    int cyc;
    do_reset();
    rom[0] = 9'o101; dur[0] = 1; rom[1] = 9'o210; dur[1] = 10;
    @(negedge clock); start = 1'b1;
    cyc = 0;
    while (cyc < 20 && !(proc_run === 1'b1 && pc_out == 5'd1)) begin
      @(negedge clock); start = 1'b0; cyc++;
    end
    checks++; if (proc_run !== 1'b1 || pc_out !== 5'd1) begin
      errors++; $display("FAIL rst_exec_pre got run=%b pc=%0d exp run=1 pc=1", proc_run, pc_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({proc_run, busy, mem_rd} !== 3'b000 || pc_out !== 5'd0 || proc_din !== 9'o0) begin
      errors++; $display("FAIL rst_exec_async got run/busy/rd=%b pc=%0d din=%o exp 000 pc=0 din=0",
                         {proc_run, busy, mem_rd}, pc_out, proc_din); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    checks++; if ({proc_run, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_exec_idle got run/busy=%b exp 00", {proc_run, busy}); end
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++; if ({busy, mem_rd} !== 2'b11 || pc_out !== 5'd0) begin
      errors++; $display("FAIL rst_exec_restart got busy/rd=%b pc=%0d exp 11 pc=0", {busy, mem_rd}, pc_out); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_step_mode();
    test_timeout();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
